// File: rtl/bus_ram_pkg.sv
// bus_ram shared constants: access-size codes and FSM states.
// Imported by bus_ram and bus_ram_lane.
package bus_ram_pkg;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic size_ok(input logic [2:0] s);
    return (s == SIZE_BYTE) || (s == SIZE_HALF) || (s == SIZE_WORD);
  endfunction

endpackage

// File: rtl/bus_ram_lane.sv
// Byte-lane steering: write mask/shift and read shift/zero-fill.
// BUS_RAM_ALIGN_CHECK_EN enables the misalignment flag.
module bus_ram_lane
  import bus_ram_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdat,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wshift,
  output logic [31:0] rdat,
  output logic        mis
);

  logic [1:0] eo;
  logic [4:0] sh;

  // offset is truncated to natural alignment for the size
  always_comb begin
    eo     = '0;
    sh     = '0;
    be     = '0;
    wshift = '0;
    rdat   = '0;
    mis    = 1'b0;
    unique case (1'b1)
      (size == SIZE_BYTE): begin
        eo     = off;
        sh     = {eo, 3'b000};
        be     = 4'b0001 << eo;
        wshift = {24'b0, wdat[7:0]} << sh;
        rdat   = {24'b0, 8'(rword >> sh)};
      end
      (size == SIZE_HALF): begin
        eo     = {off[1], 1'b0};
        sh     = {eo, 3'b000};
        be     = 4'b0011 << eo;
        wshift = {16'b0, wdat[15:0]} << sh;
        rdat   = {16'b0, 16'(rword >> sh)};
      end
      (size == SIZE_WORD): begin
        be     = 4'b1111;
        wshift = wdat;
        rdat   = rword;
      end
      default: ;
    endcase
`ifdef BUS_RAM_ALIGN_CHECK_EN
    mis = ((size == SIZE_HALF) && off[0]) ||
          ((size == SIZE_WORD) && (off != 2'b00));
`endif
  end

endmodule

// File: rtl/bus_ram.sv
// Word RAM on a req/done bus with optional wait states.
// Define BUS_RAM_ALIGN_CHECK_EN to reject misaligned accesses.
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE        = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [2:0]  byteNr_i,
  output logic [31:0] dat_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t state, state_nx;
  logic [3:0] cnt;

  logic [31:0] adr_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic [2:0]  size_q;

  logic [31:0] mem [DEPTH];

  logic        start;
  logic        go;
  logic [31:0] a_adr;
  logic [31:0] a_dat;
  logic        a_we;
  logic [2:0]  a_size;
  logic [31:0] rel;
  logic [AW-1:0] widx;
  logic        out_rng;
  logic        err;

  logic [3:0]  be;
  logic [31:0] wshift;
  logic [31:0] rdat;
  logic        mis;

  logic [31:0] rd_q;
  logic        er_q;

  assign start = (state == IDLE) && req_i;

  // with no wait states the access completes straight off the inputs
  assign a_adr  = (state == IDLE) ? adr_i    : adr_q;
  assign a_dat  = (state == IDLE) ? dat_i    : wd_q;
  assign a_we   = (state == IDLE) ? we_i     : we_q;
  assign a_size = (state == IDLE) ? byteNr_i : size_q;

  assign rel     = a_adr - BASE;
  assign widx    = rel[AW+1:2];
  assign out_rng = (a_adr < BASE) ||
                   ({2'b00, rel[31:2]} >= 32'(DEPTH));
  assign err     = !size_ok(a_size) || out_rng || mis;

  assign go = (state_nx == RESP) && !rst_i;

  bus_ram_lane u_lane (
    .size   (a_size),
    .off    (rel[1:0]),
    .wdat   (a_dat),
    .rword  (mem[widx]),
    .be     (be),
    .wshift (wshift),
    .rdat   (rdat),
    .mis    (mis)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_i) state_nx = (WAIT_STATES > 0) ? BUSY : RESP;
      BUSY: if (cnt == 4'd0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // wait-state counter
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt <= '0;
    else if (start)
      cnt <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    else if ((state == BUSY) && (cnt != 4'd0))
      cnt <= cnt - 4'd1;
  end

  // capture the request so later input changes are ignored
  always_ff @(posedge clk_i) begin
    if (start) begin
      adr_q  <= adr_i;
      wd_q   <= dat_i;
      we_q   <= we_i;
      size_q <= byteNr_i;
    end
  end

  // response registers are only non-zero during RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
      er_q <= 1'b0;
    end else if (go) begin
      rd_q <= (a_we || err) ? 32'd0 : rdat;
      er_q <= err;
    end else begin
      rd_q <= '0;
      er_q <= 1'b0;
    end
  end

  // byte-lane write on the edge entering RESP
  always_ff @(posedge clk_i) begin
    if (go && a_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  assign done_o = (state == RESP);
  assign dat_o  = rd_q;
  assign err_o  = er_q;

endmodule
